// File: rtl/line_window_buffer.sv
// Raster line window buffer: chains LineCount line RAMs and emits one vertical pixel column per
// accepted pixel, one cycle later, with rows above the current frame's first row masked to zero.
module line_window_buffer #(
    parameter int unsigned ImageWidth = 640,
    parameter int unsigned DataWidth  = 1,
    parameter int unsigned LineCount  = 2,
    localparam int unsigned AddrWidth = $clog2(ImageWidth)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 frame_start_i,
    input  logic                                 pixel_valid_i,
    input  logic [DataWidth-1:0]                 pixel_i,
    output logic                                 column_valid_o,
    output logic [(LineCount+1)*DataWidth-1:0]   column_o,
    output logic [AddrWidth-1:0]                 column_x_o,
    output logic                                 line_end_o,
    output logic                                 window_ready_o
);

    localparam int unsigned FillWidth = $clog2(LineCount + 1);
    localparam int unsigned ColWidth  = (LineCount + 1) * DataWidth;

    logic [AddrWidth-1:0] col_q, col_d, col_eff;
    logic [FillWidth-1:0] fill_q, fill_d, fill_eff;
    logic                 last_col;

    logic [DataWidth-1:0] line_mem [LineCount][ImageWidth];
    logic [DataWidth-1:0] line_rd  [LineCount];
    logic [DataWidth-1:0] line_wr  [LineCount];

    logic                 valid_q;
    logic [ColWidth-1:0]  column_q, column_d;
    logic [AddrWidth-1:0] x_q;
    logic                 line_end_q;
    logic                 ready_q, ready_d;

    always_comb begin
        // A frame start restarts the pixel at column 0 with no valid rows above it.
        col_eff  = frame_start_i ? '0 : col_q;
        fill_eff = frame_start_i ? '0 : fill_q;
        last_col = (col_eff == AddrWidth'(ImageWidth - 1));

        for (int k = 0; k < int'(LineCount); k++) begin
            line_rd[k] = line_mem[k][col_eff];
        end
        line_wr[0] = pixel_i;
        for (int k = 1; k < int'(LineCount); k++) begin
            line_wr[k] = line_rd[k-1];
        end

        column_d                = '0;
        column_d[DataWidth-1:0] = pixel_i;
        for (int k = 1; k <= int'(LineCount); k++) begin
            if (int'(fill_eff) >= k) begin
                column_d[k*DataWidth +: DataWidth] = line_rd[k-1];
            end
        end

        ready_d = (fill_eff == FillWidth'(LineCount));

        col_d  = col_q;
        fill_d = fill_q;
        if (pixel_valid_i) begin
            col_d  = last_col ? '0 : col_eff + 1'b1;
            fill_d = (last_col && (fill_eff != FillWidth'(LineCount))) ? fill_eff + 1'b1
                                                                        : fill_eff;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q      <= '0;
            fill_q     <= '0;
            valid_q    <= 1'b0;
            column_q   <= '0;
            x_q        <= '0;
            line_end_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            fill_q     <= fill_d;
            valid_q    <= pixel_valid_i;
            line_end_q <= pixel_valid_i && last_col;
            if (pixel_valid_i) begin
                column_q <= column_d;
                x_q      <= col_eff;
                ready_q  <= ready_d;
            end
        end
    end

    // Line RAMs are never reset; stale contents are hidden by the fill-count mask.
    always_ff @(posedge clk_i) begin
        if (pixel_valid_i) begin
            for (int k = 0; k < int'(LineCount); k++) begin
                line_mem[k][col_eff] <= line_wr[k];
            end
        end
    end

    assign column_valid_o = valid_q;
    assign column_o       = column_q;
    assign column_x_o     = x_q;
    assign line_end_o     = line_end_q;
    assign window_ready_o = ready_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: a row-history model predicts each column when a pixel
// is driven; predictions are popped and compared when the DUT raises column_valid_o.
module tb_line_window_buffer;

    localparam int unsigned IW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned LC = 2;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = (LC + 1) * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fs = 1'b0;
    logic          pv = 1'b0;
    logic [DW-1:0] pix = '0;

    logic          column_valid;
    logic [CW-1:0] column;
    logic [AW-1:0] column_x;
    logic          line_end;
    logic          window_ready;

    line_window_buffer #(
        .ImageWidth (IW),
        .DataWidth  (DW),
        .LineCount  (LC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_start_i  (fs),
        .pixel_valid_i  (pv),
        .pixel_i        (pix),
        .column_valid_o (column_valid),
        .column_o       (column),
        .column_x_o     (column_x),
        .line_end_o     (line_end),
        .window_ready_o (window_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [AW-1:0] x;
        logic          le;
        logic          rdy;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: full pixel history of the current frame, indexed by row and column.
    int            m_row = 0;
    int            m_col = 0;
    logic [DW-1:0] m_pix [64][IW];

    task automatic send(input logic f, input logic [DW-1:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        fs  = f;
        pv  = 1'b1;
        pix = p;
        if (f) begin
            m_row = 0;
            m_col = 0;
        end
        m_pix[m_row][m_col] = p;
        e.col = '0;
        for (int k = 0; k <= int'(LC); k++) begin
            if (m_row >= k) e.col[k*DW +: DW] = m_pix[m_row-k][m_col];
        end
        e.x   = AW'(m_col);
        e.le  = (m_col == int'(IW) - 1);
        e.rdy = (m_row >= int'(LC));
        sb.push_back(e);
        m_col++;
        if (m_col == int'(IW)) begin
            m_col = 0;
            if (m_row < 63) m_row++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fs  = 1'b0;
            pv  = 1'b0;
            pix = 8'($urandom);
        end
    endtask

    task automatic send_row(input logic f, input logic [DW-1:0] base);
        for (int c = 0; c < int'(IW); c++) send(f && (c == 0), base + DW'(c));
    endtask

    logic          pv_s;
    logic [CW-1:0] last_col = '0;
    logic [AW-1:0] last_x = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv_s <= 1'b0;
        else        pv_s <= pv;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check_eq("valid", 32'(column_valid), 32'(pv_s));
            if (column_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_column", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("column", 32'(column), 32'(e.col));
                    check_eq("column_x", 32'(column_x), 32'(e.x));
                    check_eq("line_end", 32'(line_end), 32'(e.le));
                    check_eq("window_ready", 32'(window_ready), 32'(e.rdy));
                    last_col = e.col;
                    last_x   = e.x;
                end
            end else begin
                check_eq("hold_column", 32'(column), 32'(last_col));
                check_eq("hold_x", 32'(column_x), 32'(last_x));
                check_eq("gap_line_end", 32'(line_end), 32'(0));
            end
        end
    end

    task automatic check_reset_outputs();
        check_eq("rst_valid", 32'(column_valid), 32'(0));
        check_eq("rst_column", 32'(column), 32'(0));
        check_eq("rst_x", 32'(column_x), 32'(0));
        check_eq("rst_line_end", 32'(line_end), 32'(0));
        check_eq("rst_ready", 32'(window_ready), 32'(0));
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // Frame A: three full rows, then a fourth row with 1- and 3-cycle gaps.
        send_row(1'b1, 8'h01);
        send_row(1'b0, 8'h11);
        send_row(1'b0, 8'h21);
        send(1'b0, 8'h31);
        idle(1);
        send(1'b0, 8'h32);
        send(1'b0, 8'h33);
        idle(3);
        send(1'b0, 8'h34);

        // Frame B: stale RAM contents must stay masked.
        send_row(1'b1, 8'h41);
        send_row(1'b0, 8'h51);
        send_row(1'b0, 8'h61);

        // Mid-line frame start at column 2.
        send(1'b0, 8'h71);
        send(1'b0, 8'h72);
        send(1'b1, 8'h73);
        send(1'b0, 8'h74);
        send(1'b0, 8'h75);
        send(1'b0, 8'h76);
        send(1'b0, 8'h77);
        send(1'b0, 8'h78);

        // Mid-line reset while a column is being presented.
        send(1'b0, 8'h81);
        @(posedge clk);
        #2;
        pv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        m_row = 0;
        m_col = 0;
        last_col = '0;
        last_x = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(1'b0, 8'h91);
        send(1'b0, 8'h92);
        send(1'b0, 8'h93);
        send(1'b0, 8'h94);
        send_row(1'b0, 8'hA1);
        send_row(1'b0, 8'hB1);

        // Random pixels with random gaps over a fresh frame.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) idle(1 + int'($urandom_range(2)));
            send(i == 0, 8'($urandom));
        end

        idle(1);
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        check_eq("drain", 32'(sb.size()), 32'(0));
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
